run_ctrl: RTL and testbench

Program-run sequencer for the 9-bit core. Accepts a level start request from the host or bench, holds the core (PC, flag registers) in reset for a fixed number of cycles, then releases it. Counts execution cycles until the core reports program end, then presents a sticky `done` until the host drops the request. Sits between the external `req`/`done` pins and the core's reset and run-enable inputs.

---
 rtl/run_ctrl.sv | 156 +++++++++++++++
 tb/tb_run_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/run_ctrl.sv
// run_ctrl -- program-run sequencer for the 9-bit core.
//
// Takes a level start request from the host, holds the core (PC, flags) in
// reset for HOLD cycles, lets it run while counting RUN cycles until the core
// reports program end, then presents a sticky done until the request drops.
//
// Ports:
//   clk        in   single clock, rising edge
//   reset      in   asynchronous, active-low reset
//   req        in   host start request (level)
//   core_done  in   program-end indication from the core
//   core_rst   out  core PC/flag reset, 1 = hold
//   core_run   out  core step enable
//   busy       out  high in HOLD and RUN
//   done       out  high only in DONE
//   timeout    out  last run ended by the watchdog
//   cycle_cnt  out  RUN cycles in current or last run (saturating)
//
// Configuration:
//   RUN_CTRL_WATCHDOG_EN  when defined, a run is forced to DONE with
//                         timeout=1 after WDOG RUN cycles without core_done.
//                         When undefined, timeout is tied to 0.

module run_ctrl #(
    parameter int CW   = 16,
    parameter int HOLD = 4,
    parameter int WDOG = 4000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic          core_done,
    output logic          core_rst,
    output logic          core_run,
    output logic          busy,
    output logic          done,
    output logic          timeout,
    output logic [CW-1:0] cycle_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);

    state_t        r_state;
    state_t        w_next;
    logic [HW-1:0] r_hold_cnt;
    logic [CW-1:0] r_cycle_cnt;
    logic          w_hold_last;
    logic          w_cnt_sat;
    logic          w_wdog;
    logic          w_start;
    logic          w_run_step;

    assign w_hold_last = (r_hold_cnt == HOLD_LAST);
    assign w_cnt_sat   = &r_cycle_cnt;
    assign w_start     = (r_state == S_IDLE) && req;
    // Every non-aborted RUN edge counts, including the one leaving RUN.
    assign w_run_step  = (r_state == S_RUN) && req;

`ifdef RUN_CTRL_WATCHDOG_EN
    localparam logic [CW-1:0] WDOG_LAST = CW'(WDOG - 1);

    // Fires on the edge that would bring the count to WDOG.
    assign w_wdog = (r_cycle_cnt == WDOG_LAST);

    logic r_timeout;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_timeout <= 1'b0;
        end else if (w_start) begin
            r_timeout <= 1'b0;
        end else if (w_run_step) begin
            // core_done on the same edge wins over the watchdog.
            r_timeout <= w_wdog && !core_done;
        end
    end

    assign timeout = r_timeout;
`else
    assign w_wdog  = 1'b0;
    assign timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic; in RUN the order is abort > core_done > watchdog.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (req) w_next = S_HOLD;
            S_HOLD: begin
                if (!req)             w_next = S_IDLE;
                else if (w_hold_last) w_next = S_RUN;
            end
            S_RUN: begin
                if (!req)                     w_next = S_IDLE;
                else if (core_done || w_wdog) w_next = S_DONE;
            end
            S_DONE: if (!req) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Hold and cycle counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hold_cnt  <= '0;
            r_cycle_cnt <= '0;
        end else if (w_start) begin
            r_hold_cnt  <= '0;
            r_cycle_cnt <= '0;
        end else begin
            if (r_state == S_HOLD)
                r_hold_cnt <= r_hold_cnt + 1'b1;
            if (w_run_step && !w_cnt_sat)
                r_cycle_cnt <= r_cycle_cnt + 1'b1;
        end
    end

    assign cycle_cnt = r_cycle_cnt;

    // Moore output decode from the registered state
    always_comb begin
        core_rst = 1'b1;
        core_run = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (r_state)
            S_IDLE: ;
            S_HOLD: busy = 1'b1;
            S_RUN: begin
                core_rst = 1'b0;
                core_run = 1'b1;
                busy     = 1'b1;
            end
            S_DONE: begin
                core_rst = 1'b0;
                done     = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_run_ctrl.sv
// Self-checking bench for run_ctrl. Expected values come from the run rules:
// a run is described by the edge of core_done, of abort and of the watchdog,
// and the outcome is the earliest of them (ties: abort > done > watchdog).

module tb_run_ctrl;

    localparam int CW   = 8;
    localparam int HOLD = 4;
    localparam int WDOG = 20;
    localparam int SAT  = (1 << CW) - 1;

`ifdef RUN_CTRL_WATCHDOG_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    // {core_rst, core_run, busy, done}
    localparam logic [3:0] ST_IDLE = 4'b1000;
    localparam logic [3:0] ST_HOLD = 4'b1010;
    localparam logic [3:0] ST_RUN  = 4'b0110;
    localparam logic [3:0] ST_DONE = 4'b0001;

    logic          clk = 1'b0;
    logic          reset;
    logic          req;
    logic          core_done;
    logic          core_rst, core_run, busy, done, timeout;
    logic [CW-1:0] cycle_cnt;
    logic [3:0]    st;

    int errors = 0;
    int checks = 0;

    assign st = {core_rst, core_run, busy, done};

    always #5 clk = ~clk;

    run_ctrl #(.CW(CW), .HOLD(HOLD), .WDOG(WDOG)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .core_done (core_done),
        .core_rst  (core_rst),
        .core_run  (core_run),
        .busy      (busy),
        .done      (done),
        .timeout   (timeout),
        .cycle_cnt (cycle_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // From IDLE: raise req and walk through HOLD into RUN. core_done is
    // randomised here because the sequencer must ignore it outside RUN.
    task automatic start_run(input string tag);
        req = 1'b1;
        for (int i = 1; i <= HOLD + 1; i++) begin
            core_done = 1'($urandom_range(0, 1));
            tick();
            checks++;
            if (st !== ((i <= HOLD) ? ST_HOLD : ST_RUN)) begin
                errors++;
                $display("FAIL %s start edge %0d status: got %b want %b", tag, i, st,
                         (i <= HOLD) ? ST_HOLD : ST_RUN);
            end
            checks++;
            if (cycle_cnt !== 0 || timeout !== 1'b0) begin
                errors++;
                $display("FAIL %s start edge %0d cnt/timeout: got %0d/%b want 0/0", tag, i,
                         cycle_cnt, timeout);
            end
        end
        core_done = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; req = 1'b0; core_done = 1'b0;
        #12;
        checks++;
        if (st !== ST_IDLE || timeout !== 1'b0 || cycle_cnt !== 0) begin
            errors++;
            $display("FAIL reset values: got st=%b to=%b cnt=%0d want st=%b to=0 cnt=0",
                     st, timeout, cycle_cnt, ST_IDLE);
        end
        tick();
        reset = 1'b1;
        // core_done alone must not start anything from IDLE
        core_done = 1'b1;
        tick();
        tick();
        checks++;
        if (st !== ST_IDLE) begin
            errors++;
            $display("FAIL idle without req: got %b want %b", st, ST_IDLE);
        end
        core_done = 1'b0;
    endtask

    task automatic test_done();
        start_run("done");
        for (int k = 1; k <= 9; k++) begin
            tick();
            checks++;
            if (st !== ST_RUN || cycle_cnt !== CW'(k)) begin
                errors++;
                $display("FAIL done run edge %0d: got st=%b cnt=%0d want st=%b cnt=%0d",
                         k, st, cycle_cnt, ST_RUN, k);
            end
        end
        core_done = 1'b1;
        tick();
        checks++;
        if (st !== ST_DONE || cycle_cnt !== 10 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL done entry: got st=%b cnt=%0d to=%b want st=%b cnt=10 to=0",
                     st, cycle_cnt, timeout, ST_DONE);
        end
        core_done = 1'b0;
        tick();
        tick();
        checks++;
        if (st !== ST_DONE || cycle_cnt !== 10) begin
            errors++;
            $display("FAIL done sticky: got st=%b cnt=%0d want st=%b cnt=10", st, cycle_cnt, ST_DONE);
        end
        req = 1'b0;
        tick();
        checks++;
        if (st !== ST_IDLE || cycle_cnt !== 10) begin
            errors++;
            $display("FAIL done release: got st=%b cnt=%0d want st=%b cnt=10", st, cycle_cnt, ST_IDLE);
        end
    endtask

    task automatic test_abort();
        start_run("abort");
        tick();
        tick();
        req = 1'b0;
        core_done = 1'b1;   // abort outranks core_done
        tick();
        core_done = 1'b0;
        checks++;
        if (st !== ST_IDLE || cycle_cnt !== 2) begin
            errors++;
            $display("FAIL abort in run: got st=%b cnt=%0d want st=%b cnt=2", st, cycle_cnt, ST_IDLE);
        end
        tick();
        checks++;
        if (st !== ST_IDLE || cycle_cnt !== 2) begin
            errors++;
            $display("FAIL abort stays idle: got st=%b cnt=%0d want st=%b cnt=2", st, cycle_cnt, ST_IDLE);
        end
        // abort during HOLD
        req = 1'b1;
        tick();
        tick();
        req = 1'b0;
        tick();
        checks++;
        if (st !== ST_IDLE || cycle_cnt !== 0) begin
            errors++;
            $display("FAIL abort in hold: got st=%b cnt=%0d want st=%b cnt=0", st, cycle_cnt, ST_IDLE);
        end
    endtask

    // core_done never arrives: watchdog ends the run, or the count saturates.
    task automatic test_watchdog();
        int exp_cnt;
        start_run("wdog");
        for (int k = 1; k <= SAT + 10; k++) begin
            tick();
            if (WD_EN && k == WDOG) begin
                checks++;
                if (st !== ST_DONE || timeout !== 1'b1 || cycle_cnt !== CW'(WDOG)) begin
                    errors++;
                    $display("FAIL watchdog fire: got st=%b to=%b cnt=%0d want st=%b to=1 cnt=%0d",
                             st, timeout, cycle_cnt, ST_DONE, WDOG);
                end
                break;
            end
            exp_cnt = (k > SAT) ? SAT : k;
            checks++;
            if (st !== ST_RUN || timeout !== 1'b0 || cycle_cnt !== CW'(exp_cnt)) begin
                errors++;
                $display("FAIL long run edge %0d: got st=%b to=%b cnt=%0d want st=%b to=0 cnt=%0d",
                         k, st, timeout, cycle_cnt, ST_RUN, exp_cnt);
            end
        end
        req = 1'b0;
        tick();
        exp_cnt = WD_EN ? WDOG : SAT;
        checks++;
        if (st !== ST_IDLE || timeout !== WD_EN || cycle_cnt !== CW'(exp_cnt)) begin
            errors++;
            $display("FAIL long run release: got st=%b to=%b cnt=%0d want st=%b to=%b cnt=%0d",
                     st, timeout, cycle_cnt, ST_IDLE, WD_EN, exp_cnt);
        end
    endtask

    // core_done on the same edge as the watchdog limit: a normal finish.
    task automatic test_wdog_tie();
        start_run("tie");
        for (int k = 1; k < WDOG; k++) tick();
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        checks++;
        if (st !== ST_DONE || timeout !== 1'b0 || cycle_cnt !== CW'(WDOG)) begin
            errors++;
            $display("FAIL done at limit: got st=%b to=%b cnt=%0d want st=%b to=0 cnt=%0d",
                     st, timeout, cycle_cnt, ST_DONE, WDOG);
        end
        req = 1'b0;
        tick();
    endtask

    task automatic test_async_reset();
        start_run("areset");
        tick();
        tick();
        tick();
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (st !== ST_IDLE || timeout !== 1'b0 || cycle_cnt !== 0) begin
            errors++;
            $display("FAIL async reset: got st=%b to=%b cnt=%0d want st=%b to=0 cnt=0",
                     st, timeout, cycle_cnt, ST_IDLE);
        end
        #2;
        reset = 1'b1;
        tick();
        checks++;
        if (st !== ST_HOLD || cycle_cnt !== 0) begin
            errors++;
            $display("FAIL fresh hold after reset: got st=%b cnt=%0d want st=%b cnt=0",
                     st, cycle_cnt, ST_HOLD);
        end
        for (int i = 2; i <= HOLD + 1; i++) tick();
        checks++;
        if (st !== ST_RUN || cycle_cnt !== 0) begin
            errors++;
            $display("FAIL run after reset: got st=%b cnt=%0d want st=%b cnt=0", st, cycle_cnt, ST_RUN);
        end
        req = 1'b0;
        tick();
    endtask

    // Random runs: core_done edge d, optional abort edge a, outcome is the
    // earliest event with ties resolved abort > done > watchdog.
    task automatic test_random();
        int d, a, end_e, kind, exp_cnt;   // kind: 0 done, 1 watchdog, 2 abort
        logic exp_to;
        for (int n = 0; n < 40; n++) begin
            d = $urandom_range(1, 30);
            a = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 30) : 0;
            end_e = d; kind = 0;
            if (WD_EN && WDOG < end_e) begin end_e = WDOG; kind = 1; end
            if (a != 0 && a <= end_e)  begin end_e = a;    kind = 2; end
            exp_cnt = (kind == 2) ? a - 1 : end_e;
            exp_to  = (kind == 1);
            start_run("rand");
            for (int e = 1; e <= end_e; e++) begin
                core_done = (e == d);
                req       = (e != a);
                tick();
                if (e < end_e) begin
                    checks++;
                    if (st !== ST_RUN || cycle_cnt !== CW'(e)) begin
                        errors++;
                        $display("FAIL rand %0d edge %0d: got st=%b cnt=%0d want st=%b cnt=%0d",
                                 n, e, st, cycle_cnt, ST_RUN, e);
                    end
                end
            end
            core_done = 1'b0;
            checks++;
            if (st !== ((kind == 2) ? ST_IDLE : ST_DONE) || cycle_cnt !== CW'(exp_cnt) ||
                timeout !== exp_to) begin
                errors++;
                $display("FAIL rand %0d end (d=%0d a=%0d): got st=%b cnt=%0d to=%b want st=%b cnt=%0d to=%b",
                         n, d, a, st, cycle_cnt, timeout, (kind == 2) ? ST_IDLE : ST_DONE,
                         exp_cnt, exp_to);
            end
            req = 1'b0;
            tick();
            checks++;
            if (st !== ST_IDLE || cycle_cnt !== CW'(exp_cnt) || timeout !== exp_to) begin
                errors++;
                $display("FAIL rand %0d idle hold: got st=%b cnt=%0d to=%b want st=%b cnt=%0d to=%b",
                         n, st, cycle_cnt, timeout, ST_IDLE, exp_cnt, exp_to);
            end
        end
    endtask

    initial begin
        test_reset();
        test_done();
        test_abort();
        test_watchdog();
        test_wdog_tie();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL sim time limit: got still running want finished");
        $fatal(1);
    end

endmodule
